ccg_stage_ctrl: RTL and testbench
=================================

CCG_STAGE_CTRL -- requirements
Module: ccg_stage_ctrl

Interface
REQ-001 Parameter DEPTH, default 1, number of pipeline register stages from accepted opcode to outputs (legal 1..4).
REQ-002 Parameter CNTW, default 8, width of the squash event counter.
REQ-003 clk  input  1  global clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  opcode/fl/wr_in are valid this cycle.
REQ-006 stall  input  1  hold all pipeline stages.
REQ-007 flush  input  1  invalidate all pipeline stages.
REQ-008 opcode  input  8  instruction opcode from stage-3 buffer.
REQ-009 fl  input  1  selected condition flag, aligned with opcode.
REQ-010 wr_in  input  1  memory-write request from the stage-3 generator, aligned with opcode.
REQ-011 out_valid  output  1  final stage holds a valid instruction.
REQ-012 wr, lrn, lr0, lsp, dsp, lop, ern, efl  output  1 each  write memory, load Rn, load R0, load SP, SP-1 passthrough, load output regs, enable Rn writeback, conditional-branch indicator.
REQ-013 squash_cnt  output  CNTW  count of squashed conditional instructions.

Function
REQ-014 Decode, ctrl = {lrn,lr0,lsp,dsp,lop,ern,efl,isp}, first match wins: 01 lrn+lr0; 05,06 dsp; 07 isp; 08-0F,28-2F efl; 10 lsp; 11-17,58-5F,71-77 lrn; 18,60,70,F0-F7 lr0; 19-1F lr0+ern; 30-3F dsp+efl; 48-4F efl+isp; 61-67 ern; 68-6F dsp+ern; 78-7F lrn+isp; 20-27,40-47,50-57 lrn+ern; 80-E7 with opcode[3]=0 lr0+ern; 88-EF with opcode[3]=1 lrn+ern; F8-FF lop; all others (00,02-04) zero.
REQ-015 Stage 1 captures {valid=in_valid, ctrl, fl, wr_in} on an edge with stall=0; stages 2..DEPTH shift forward on the same edges.
REQ-016 Latency: an input accepted at edge N appears at outputs after edge N+DEPTH-1, given no stall.
REQ-017 stall=1, flush=0: every stage, including valid bits, holds.
REQ-018 flush=1: all valid bits cleared on the next edge; flush overrides stall and in_valid.
REQ-019 Squash condition sq = out_valid & efl_r & ~fl_r, where efl_r/fl_r are final-stage values.
REQ-020 wr = out_valid & wr_r & ~sq.
REQ-021 dsp = out_valid & ((isp_r & sq) | (dsp_r & ~sq)): a conditional call pushes only when taken; a conditional return pops only when not taken.
REQ-022 lrn, lr0, lsp, lop, ern, efl = final-stage bit AND out_valid; these are not gated by sq.
REQ-023 squash_cnt increments by 1 on each edge where sq=1 and stall=0; it saturates at 2^CNTW-1 and does not wrap.
REQ-024 With stall=1, sq is still output combinationally, but squash_cnt does not count the held instruction again.
REQ-025 isp is internal only and is not a port.

Reset
REQ-026 rst=1 immediately clears all valid bits, stage ctrl/fl/wr registers and squash_cnt; all outputs read 0 while rst=1.
REQ-027 Reset asserted mid-stall or mid-flush discards all in-flight instructions; the first accepted input after reset release follows REQ-016.

Verification
REQ-028 DEPTH=1: in_valid=1, opcode=0x01 at edge 0 -> after edge 0, out_valid=1, lrn=1, lr0=1, all other outputs 0.
REQ-029 DEPTH=2: opcode=0x38 (CCA), fl=0 -> two edges later, efl=1, dsp=0, squash_cnt=1; repeat with fl=1 -> dsp=1, squash_cnt unchanged.
REQ-030 opcode=0x48 (RTC), fl=1 -> dsp=0; fl=0 -> dsp=1. opcode=0x6A, wr_in=1 -> wr=1, ern=1, dsp=1.
REQ-031 DEPTH=3: stream 0x11,0x19,0xF8; hold stall=1 for 2 cycles mid-stream -> outputs freeze; order and count preserved. Assert flush with stall=1 -> out_valid=0 after the next edge.
REQ-032 CNTW=2: five squashing 0x08 instructions with fl=0 -> squash_cnt 1,2,3,3,3; assert rst asynchronously between edges -> squash_cnt=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/ccg_stage_ctrl.sv
// Stage-3 control decoder followed by a DEPTH-deep stall/flush pipeline.
// The final stage drives the gated control outputs and a saturating squash counter.
module ccg_stage_ctrl #(
  parameter int DEPTH = 1,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [7:0]      opcode,
  input  logic            fl,
  input  logic            wr_in,
  output logic            out_valid,
  output logic            wr,
  output logic            lrn,
  output logic            lr0,
  output logic            lsp,
  output logic            dsp,
  output logic            lop,
  output logic            ern,
  output logic            efl,
  output logic [CNTW-1:0] squash_cnt
);

  // ctrl bit order: {lrn, lr0, lsp, dsp, lop, ern, efl, isp}
  logic [7:0]      ctrl_d;
  logic            valid_q [DEPTH];
  logic [7:0]      ctrl_q  [DEPTH];
  logic            fl_q    [DEPTH];
  logic            wr_q    [DEPTH];
  logic [CNTW-1:0] cnt_q;

  logic lrn_r, lr0_r, lsp_r, dsp_r, lop_r, ern_r, efl_r, isp_r;
  logic fl_r, wr_r, sq;

  // First matching pattern wins; the order of this chain matters.
  always_comb begin
    ctrl_d = 8'b0000_0000;
    if      (opcode ==  8'h01)        ctrl_d = 8'b1100_0000;
    else if (opcode ==  8'h05 ||
             opcode ==  8'h06)        ctrl_d = 8'b0001_0000;
    else if (opcode ==  8'h07)        ctrl_d = 8'b0000_0001;
    else if (opcode ==? 8'b0000_1??? ||
             opcode ==? 8'b0010_1???) ctrl_d = 8'b0000_0010;
    else if (opcode ==  8'h10)        ctrl_d = 8'b0010_0000;
    else if (opcode ==? 8'b0001_0??? ||
             opcode ==? 8'b0101_1??? ||
             (opcode ==? 8'b0111_0??? && opcode != 8'h70))
                                      ctrl_d = 8'b1000_0000;
    else if (opcode ==  8'h18 || opcode == 8'h60 || opcode == 8'h70 ||
             opcode ==? 8'b1111_0???) ctrl_d = 8'b0100_0000;
    else if (opcode ==? 8'b0001_1???) ctrl_d = 8'b0100_0100;
    else if (opcode ==? 8'b0011_????) ctrl_d = 8'b0001_0010;
    else if (opcode ==? 8'b0100_1???) ctrl_d = 8'b0000_0011;
    else if (opcode ==? 8'b0110_0???) ctrl_d = 8'b0000_0100;
    else if (opcode ==? 8'b0110_1???) ctrl_d = 8'b0001_0100;
    else if (opcode ==? 8'b0111_1???) ctrl_d = 8'b1000_0001;
    else if (opcode ==? 8'b0010_0??? ||
             opcode ==? 8'b0100_0??? ||
             opcode ==? 8'b0101_0???) ctrl_d = 8'b1000_0100;
    else if (opcode ==? 8'b1111_1???) ctrl_d = 8'b0000_1000;
    else if (opcode ==? 8'b1???_0???) ctrl_d = 8'b0100_0100;
    else if (opcode ==? 8'b1???_1???) ctrl_d = 8'b1000_0100;
  end

  // Transfer rule: an edge with stall=0 accepts the input slot (valid=in_valid)
  // and advances every stage; flush wins over stall and clears all valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= 8'h00;
        fl_q[i]    <= 1'b0;
        wr_q[i]    <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      if (!stall && sq && cnt_q != {CNTW{1'b1}})
        cnt_q <= cnt_q + 1'b1;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else if (!stall) begin
        valid_q[0] <= in_valid;
        ctrl_q[0]  <= ctrl_d;
        fl_q[0]    <= fl;
        wr_q[0]    <= wr_in;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          ctrl_q[i]  <= ctrl_q[i-1];
          fl_q[i]    <= fl_q[i-1];
          wr_q[i]    <= wr_q[i-1];
        end
      end
    end
  end

  always_comb begin
    {lrn_r, lr0_r, lsp_r, dsp_r, lop_r, ern_r, efl_r, isp_r} = ctrl_q[DEPTH-1];
    fl_r      = fl_q[DEPTH-1];
    wr_r      = wr_q[DEPTH-1];
    out_valid = valid_q[DEPTH-1];
    sq        = out_valid & efl_r & ~fl_r;
    // Conditional call pushes only when taken; conditional return pops only when not taken.
    dsp       = out_valid & ((isp_r & sq) | (dsp_r & ~sq));
    wr        = out_valid & wr_r & ~sq;
    lrn       = out_valid & lrn_r;
    lr0       = out_valid & lr0_r;
    lsp       = out_valid & lsp_r;
    lop       = out_valid & lop_r;
    ern       = out_valid & ern_r;
    efl       = out_valid & efl_r;
  end

  assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_ccg_stage_ctrl.sv
// Bench for ccg_stage_ctrl: four parameter sets share one stimulus stream and
// are compared every cycle against a queue-based reference plus literal pins.
module tb_ccg_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, stall, flush, fl, wr_in;
  logic [7:0] opcode;

  // Per instance: {out_valid, wr, lrn, lr0, lsp, dsp, lop, ern, efl}
  logic [3:0][8:0] o_vec;
  logic [3:0][7:0] c_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 2) ? 3 : (g == 1) ? 2 : 1;
    localparam int C = (g == 3) ? 2 : 8;
    logic [C-1:0] cnt;
    ccg_stage_ctrl #(.DEPTH(D), .CNTW(C)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .opcode(opcode), .fl(fl), .wr_in(wr_in),
      .out_valid(o_vec[g][8]), .wr(o_vec[g][7]), .lrn(o_vec[g][6]), .lr0(o_vec[g][5]),
      .lsp(o_vec[g][4]), .dsp(o_vec[g][3]), .lop(o_vec[g][2]), .ern(o_vec[g][1]),
      .efl(o_vec[g][0]), .squash_cnt(cnt)
    );
    assign c_vec[g] = 8'(cnt);
  end

  function automatic int dep(int k);
    return (k == 2) ? 3 : (k == 1) ? 2 : 1;
  endfunction

  function automatic int cmax(int k);
    return (k == 3) ? 3 : 255;
  endfunction

  // Reference decode, {lrn, lr0, lsp, dsp, lop, ern, efl, isp}
  function automatic logic [7:0] ref_ctrl(logic [7:0] op);
    if (op == 8'h01) return 8'b1100_0000;
    if (op inside {8'h05, 8'h06}) return 8'b0001_0000;
    if (op == 8'h07) return 8'b0000_0001;
    if (op inside {[8'h08:8'h0F], [8'h28:8'h2F]}) return 8'b0000_0010;
    if (op == 8'h10) return 8'b0010_0000;
    if (op inside {[8'h11:8'h17], [8'h58:8'h5F], [8'h71:8'h77]}) return 8'b1000_0000;
    if (op inside {8'h18, 8'h60, 8'h70, [8'hF0:8'hF7]}) return 8'b0100_0000;
    if (op inside {[8'h19:8'h1F]}) return 8'b0100_0100;
    if (op inside {[8'h30:8'h3F]}) return 8'b0001_0010;
    if (op inside {[8'h48:8'h4F]}) return 8'b0000_0011;
    if (op inside {[8'h61:8'h67]}) return 8'b0000_0100;
    if (op inside {[8'h68:8'h6F]}) return 8'b0001_0100;
    if (op inside {[8'h78:8'h7F]}) return 8'b1000_0001;
    if (op inside {[8'h20:8'h27], [8'h40:8'h47], [8'h50:8'h57]}) return 8'b1000_0100;
    if (op inside {[8'h80:8'hEF]}) return op[3] ? 8'b1000_0100 : 8'b0100_0100;
    if (op inside {[8'hF8:8'hFF]}) return 8'b0000_1000;
    return 8'b0000_0000;
  endfunction

  // Entry layout: {valid, ctrl[7:0], fl, wr}
  function automatic logic ref_sq(logic [10:0] e);
    return e[10] & e[3] & ~e[1];
  endfunction

  function automatic logic [8:0] ref_out(logic [10:0] e);
    logic v, lrn_e, lr0_e, lsp_e, dsp_e, lop_e, ern_e, efl_e, isp_e, f, w, s;
    {v, lrn_e, lr0_e, lsp_e, dsp_e, lop_e, ern_e, efl_e, isp_e, f, w} = e;
    s = ref_sq(e);
    return {v, v & w & ~s, v & lrn_e, v & lr0_e, v & lsp_e,
            v & ((isp_e & s) | (dsp_e & ~s)), v & lop_e, v & ern_e, v & efl_e};
  endfunction

  // Reference model: front of each queue is the newest stage, back is the output stage.
  logic [10:0] mq [4][$];
  int          mcnt [4];

  always @(posedge clk or posedge rst) begin
    logic [10:0] e;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mq[k] = {};
        for (int i = 0; i < dep(k); i++) mq[k].push_back(11'h000);
        mcnt[k] = 0;
      end else begin
        e = mq[k][$];
        if (!stall && ref_sq(e) && mcnt[k] < cmax(k)) mcnt[k]++;
        if (flush) begin
          for (int i = 0; i < mq[k].size(); i++) begin
            e = mq[k][i];
            e[10] = 1'b0;
            mq[k][i] = e;
          end
        end else if (!stall) begin
          mq[k].push_front({in_valid, ref_ctrl(opcode), fl, wr_in});
          void'(mq[k].pop_back());
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] exp_o;
    for (int k = 0; k < 4; k++) begin
      exp_o = (mq[k].size() == 0) ? 9'h000 : ref_out(mq[k][$]);
      n_checks++;
      if (o_vec[k] !== exp_o) begin
        n_errors++;
        $display("FAIL model_out[%0d] t=%0t got=%b exp=%b", k, $time, o_vec[k], exp_o);
      end
      n_checks++;
      if (c_vec[k] !== 8'(mcnt[k])) begin
        n_errors++;
        $display("FAIL model_cnt[%0d] t=%0t got=%0d exp=%0d", k, $time, c_vec[k], mcnt[k]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] op, input logic f, input logic w);
    in_valid = v;
    opcode   = op;
    fl       = f;
    wr_in    = w;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) step();
    chk("reset_out", 64'(o_vec), 64'd0);
    chk("reset_cnt", 64'(c_vec), 64'd0);
    rst = 1'b0;

    // Single-stage decode of 0x01
    drv(1'b1, 8'h01, 1'b0, 1'b0);
    step();
    chk("d1_op01", 64'(o_vec[0]), 64'(9'b1_0_1_1_0_0_0_0_0));
    chk("d1_op01_cnt", 64'(c_vec[0]), 64'd0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();

    // Conditional call 0x38 on the two-stage instance
    drv(1'b1, 8'h38, 1'b0, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("d2_cca_nt", 64'(o_vec[1]), 64'(9'b1_0_0_0_0_0_0_0_1));
    step();
    chk("d2_cca_nt_cnt", 64'(c_vec[1]), 64'd1);
    drv(1'b1, 8'h38, 1'b1, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("d2_cca_tk", 64'(o_vec[1]), 64'(9'b1_0_0_0_0_1_0_0_1));
    step();
    chk("d2_cca_tk_cnt", 64'(c_vec[1]), 64'd1);

    // Conditional return and write path on the single-stage instance
    drv(1'b1, 8'h48, 1'b1, 1'b0);
    step();
    chk("d1_rtc_tk", 64'(o_vec[0]), 64'(9'b1_0_0_0_0_0_0_0_1));
    drv(1'b1, 8'h48, 1'b0, 1'b0);
    step();
    chk("d1_rtc_nt", 64'(o_vec[0]), 64'(9'b1_0_0_0_0_1_0_0_1));
    drv(1'b1, 8'h6A, 1'b0, 1'b1);
    step();
    chk("d1_op6a_wr", 64'(o_vec[0]), 64'(9'b1_1_0_0_0_1_0_1_0));
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();

    // Three-stage stream with a two-cycle stall once 0x11 reaches the output
    drv(1'b1, 8'h11, 1'b0, 1'b0); step();
    drv(1'b1, 8'h19, 1'b0, 1'b0); step();
    drv(1'b1, 8'hF8, 1'b0, 1'b0); step();
    chk("d3_first", 64'(o_vec[2]), 64'(9'b1_0_1_0_0_0_0_0_0));
    stall = 1'b1;
    drv(1'b1, 8'h01, 1'b0, 1'b0);
    step();
    chk("d3_stall1", 64'(o_vec[2]), 64'(9'b1_0_1_0_0_0_0_0_0));
    step();
    chk("d3_stall2", 64'(o_vec[2]), 64'(9'b1_0_1_0_0_0_0_0_0));
    stall = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("d3_second", 64'(o_vec[2]), 64'(9'b1_0_0_1_0_0_0_1_0));
    step();
    chk("d3_third", 64'(o_vec[2]), 64'(9'b1_0_0_0_0_0_1_0_0));
    step();
    chk("d3_drained", 64'(o_vec[2]), 64'd0);

    // Flush during stall
    drv(1'b1, 8'h11, 1'b0, 1'b0); step();
    drv(1'b0, 8'h00, 1'b0, 1'b0); step();
    step();
    chk("d3_pre_flush_valid", 64'(o_vec[2][8]), 64'd1);
    stall = 1'b1; flush = 1'b1;
    drv(1'b1, 8'h01, 1'b0, 1'b0);
    step();
    chk("d3_flush_stall", 64'(o_vec[2]), 64'd0);
    chk("d1_flush_stall", 64'(o_vec[0]), 64'd0);
    stall = 1'b0; flush = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Sweep all opcodes with mixed flags and sprinkled stall/flush
    for (int op = 0; op < 256; op++) begin
      drv(1'b1, 8'(op), op[1] ^ op[4], op[0]);
      stall = (op % 17 == 5);
      flush = (op % 31 == 30);
      step();
    end
    stall = 1'b0; flush = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) step();

    // Saturation with a 2-bit counter
    rst = 1'b1; step(); rst = 1'b0;
    drv(1'b1, 8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 4) drv(1'b0, 8'h00, 1'b0, 1'b0);
      if (i > 0) chk($sformatf("cntw2_sat_%0d", i), 64'(c_vec[3]), 64'((i >= 3) ? 3 : i));
    end

    // Asynchronous reset between edges, held across a stalled/flushing edge
    drv(1'b1, 8'h08, 1'b0, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 64'(c_vec[3]), 64'd0);
    chk("async_rst_out", 64'(o_vec), 64'd0);
    stall = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drv(1'b1, 8'h01, 1'b0, 1'b0);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_d1", 64'(o_vec[0]), 64'(9'b1_0_1_1_0_0_0_0_0));
    chk("post_rst_d2_early", 64'(o_vec[1]), 64'd0);
    step();
    chk("post_rst_d2", 64'(o_vec[1]), 64'(9'b1_0_1_1_0_0_0_0_0));
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
